uart_rx_8n1: RTL and testbench

//  Serial UART receiver (8N1 default, 16x oversampling, internal baud-tick generator).

---
 rtl/uart_rx_8n1.sv | 95 +++++++++
 tb/tb_uart_rx_8n1.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 16x-oversampled UART receiver with internal baud-tick generator
module uart_rx_8n1 #(
  parameter int BAUD_DIV  = 163,
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 top_clk,
  input  logic                 top_rst_n,
  input  logic                 rx,
  output logic                 rx_done_tick,
  output logic [DATA_BITS-1:0] rx_bus,
  output logic                 frame_err,
  output logic                 rx_busy
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt_q;
  logic s_tick;
  logic [3:0] s_cnt_q, s_cnt_d;
  logic [2:0] n_q, n_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, bus_d;
  logic done_d, ferr_d;
  assign s_tick = cnt_q == CW'(BAUD_DIV - 1);
  assign rx_busy = state_q != IDLE;
  // free-running: the baud grid is never re-aligned to the start edge
  always_ff @(posedge top_clk or negedge top_rst_n)
    if (!top_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      cnt_q <= '0;
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_q <= '0;
      shift_q <= '0;
      rx_bus <= '0;
      rx_done_tick <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      cnt_q <= s_tick ? '0 : cnt_q + 1'b1;
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_q <= n_d;
      shift_q <= shift_d;
      rx_bus <= bus_d;
      rx_done_tick <= done_d;
      frame_err <= ferr_d;
    end
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d = n_q;
    shift_d = shift_q;
    bus_d = rx_bus;
    done_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      IDLE:
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      START:
        if (s_tick) begin
          if (s_cnt_q == 4'd7) begin
            state_d = rx_s ? IDLE : DATA;
            s_cnt_d = '0;
            n_d = '0;
          end else s_cnt_d = s_cnt_q + 4'd1;
        end
      DATA:
        if (s_tick) begin
          if (s_cnt_q == 4'd15) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            state_d = n_q == 3'(DATA_BITS - 1) ? STOP : DATA;
            n_d = n_q == 3'(DATA_BITS - 1) ? n_q : n_q + 3'd1;
          end else s_cnt_d = s_cnt_q + 4'd1;
        end
      STOP:
        if (s_tick) begin
          if (s_cnt_q == 4'(SB_TICKS - 1)) begin
            state_d = IDLE;
            bus_d = rx_s ? shift_q : rx_bus;
            done_d = rx_s;
            ferr_d = !rx_s;
          end else s_cnt_d = s_cnt_q + 4'd1;
        end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed and random frames checked against a byte/event queue model
module tb_uart_rx_8n1;
  localparam int BIT = 64;
  logic top_clk = 1'b0;
  logic top_rst_n = 1'b0;
  logic rx = 1'b1;
  logic rx_done_tick, frame_err, rx_busy;
  logic [7:0] rx_bus;
  int cmp = 0, mis = 0, both = 0, longp = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] b;
  logic good, prev_good;

  uart_rx_8n1 #(.BAUD_DIV(4)) dut (
    .top_clk(top_clk), .top_rst_n(top_rst_n), .rx(rx),
    .rx_done_tick(rx_done_tick), .rx_bus(rx_bus),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 top_clk = ~top_clk;

  // event recorder: {is_frame_err, rx_bus} per pulse
  always @(negedge top_clk) begin
    if (rx_done_tick) obs_q.push_back({1'b0, rx_bus});
    if (frame_err) obs_q.push_back({1'b1, rx_bus});
    if (rx_done_tick && frame_err) both <= both + 1;
    if ((rx_done_tick && prev_done) || (frame_err && prev_err)) longp <= longp + 1;
    prev_done <= rx_done_tick;
    prev_err <= frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    cmp++;
    assert (o === e) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge top_clk);
  endtask

  // bad stop bit is low only long enough to cover its sample point, so the
  // receiver's immediate restart sees a high line and aborts cleanly
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (stop) send_bit(1'b1);
    else begin
      rx = 1'b0;
      repeat (40) @(negedge top_clk);
      rx = 1'b1;
      repeat (BIT - 40) @(negedge top_clk);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic stop);
    if (stop) last_good = d;
    exp_q.push_back({!stop, stop ? d : last_good});
  endtask

  task automatic check_events(input string tag);
    repeat (20) @(negedge top_clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (10) @(negedge top_clk);
    chk("rst_done", rx_done_tick, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_bus", rx_bus, 0);
    top_rst_n = 1'b1;
    repeat (40) @(negedge top_clk);
    chk("idle_busy", rx_busy, 0);
    check_events("idle");

    send_frame(8'h63, 1'b1);
    expect_frame(8'h63, 1'b1);
    check_events("c");
    chk("c_bus", rx_bus, 8'h63);

    rx = 1'b0;
    repeat (20) @(negedge top_clk);
    chk("glitch_busy_hi", rx_busy, 1);
    rx = 1'b1;
    repeat (60) @(negedge top_clk);
    chk("glitch_busy_lo", rx_busy, 0);
    check_events("glitch");

    send_frame(8'h73, 1'b1);
    send_frame(8'h72, 1'b1);
    expect_frame(8'h73, 1'b1);
    expect_frame(8'h72, 1'b1);
    check_events("b2b");
    chk("b2b_bus", rx_bus, 8'h72);

    send_frame(8'h63, 1'b1);
    send_frame(8'h52, 1'b0);
    expect_frame(8'h63, 1'b1);
    expect_frame(8'h52, 1'b0);
    check_events("ferr");
    chk("ferr_bus", rx_bus, 8'h63);
    repeat (BIT) @(negedge top_clk);

    b = 8'h43;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    repeat (20) @(negedge top_clk);
    top_rst_n = 1'b0;
    rx = 1'b1;
    #1;
    chk("mid_rst_busy", rx_busy, 0);
    chk("mid_rst_bus", rx_bus, 0);
    repeat (10) @(negedge top_clk);
    top_rst_n = 1'b1;
    last_good = 8'h00;
    repeat (100) @(negedge top_clk);
    chk("post_rst_busy", rx_busy, 0);
    send_frame(8'h53, 1'b1);
    expect_frame(8'h53, 1'b1);
    check_events("rst_frame");
    chk("rst_frame_bus", rx_bus, 8'h53);

    prev_good = 1'b1;
    for (int k = 0; k < 14; k++) begin
      b = 8'($urandom);
      good = $urandom_range(0, 3) != 0;
      repeat (prev_good ? $urandom_range(0, 150) : BIT + $urandom_range(0, 100)) @(negedge top_clk);
      send_frame(b, good);
      expect_frame(b, good);
      prev_good = good;
    end
    check_events("rand");
    chk("rand_bus", rx_bus, last_good);
    chk("both_high", both, 0);
    chk("pulse_width", longp, 0);
    chk("end_busy", rx_busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
